// File: rtl/dm_sync_ws_pkg.sv
// Shared encodings and helpers for the wait-state data memory.
package dm_sync_ws_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;

  localparam logic [1:0] MEM_op_word = 2'b00;
  localparam logic [1:0] MEM_op_half = 2'b01;
  localparam logic [1:0] MEM_op_byte = 2'b10;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // Request fields latched on accept (address kept separately: parametrised width)
  typedef struct packed {
    logic        we;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] din;
  } dm_req_t;

  // Reserved mode 2'b11 falls into the word rule
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] lo);
    logic mis;
    case (mode)
      MEM_op_half: mis = lo[0];
      MEM_op_byte: mis = 1'b0;
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Selects the addressed byte/half/word lane and sign- or zero-extends it.
module dm_load_align
  import dm_sync_ws_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mode,
  input  logic        sext,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_c = word[7:0];
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      default: byte_c = word[31:24];
    endcase
    half_c = addr_lo[1] ? word[31:16] : word[15:0];
    case (mode)
      MEM_op_byte: data_c = {{24{sext & byte_c[7]}}, byte_c};
      MEM_op_half: data_c = {{16{sext & half_c[15]}}, half_c};
      default:     data_c = word;
    endcase
  end

endmodule

// File: rtl/dm_sync_ws.sv
// Synchronous-read data memory with req/ready/done handshake and programmable wait states.
module dm_sync_ws
  import dm_sync_ws_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  input  logic [1:0]            mode,
  input  logic                  sext,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           dout,
  output logic                  misalign
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [31:0] mem [DEPTH];

  dm_state_e             state_q, state_d;
  dm_req_t               req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  misalign_q, misalign_d;
  logic [31:0]           dout_q, dout_d;

  logic                  accept_c, mis_c, access_c;
  logic [IDX_W-1:0]      idx_c;
  logic [LANES-1:0]      be_c;
  logic [31:0]           wdata_c, load_c;

  assign accept_c = (state_q == DM_IDLE) && req;
  assign mis_c    = is_misaligned(mode, addr[1:0]);
  assign access_c = (state_q == DM_WAIT) && (cnt_q == '0);
  assign idx_c    = addr_q[ADDR_WIDTH-1:2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DM_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DM_IDLE: if (req) state_d = mis_c ? DM_RESP : DM_WAIT;
      DM_WAIT: if (cnt_q == '0) state_d = DM_RESP;
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    misalign_d = 1'b0;
    ready_d    = (state_d == DM_IDLE);
    done_d     = (state_d == DM_RESP);
    if (accept_c) begin
      req_d  = '{we: we, mode: mode, sext: sext, din: din};
      addr_d = addr;
      cnt_d  = CNT_W'(WAIT_CYCLES);
      if (mis_c) begin
        misalign_d = 1'b1;
        dout_d     = '0;
      end
    end
    if (state_q == DM_WAIT && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    if (access_c && !req_q.we) dout_d = load_c;
  end

  // Registered outputs and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      dout_q     <= dout_d;
    end
  end

  // Latched request needs no reset: only consumed after a fresh accept
  always_ff @(posedge clk) begin
    req_q  <= req_d;
    addr_q <= addr_d;
  end

  // Store lane enables, sub-word data replicated onto every lane
  always_comb begin
    case (req_q.mode)
      MEM_op_byte: begin
        be_c    = LANES'(4'b0001 << addr_q[1:0]);
        wdata_c = {4{req_q.din[7:0]}};
      end
      MEM_op_half: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_q.din[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_q.din;
      end
    endcase
  end

  // Reset blocks the write so an interrupted store never lands
  always_ff @(posedge clk) begin
    if (!rst && access_c && req_q.we) begin
      for (int l = 0; l < LANES; l++) begin
        if (be_c[l]) mem[idx_c][8*l +: 8] <= wdata_c[8*l +: 8];
      end
    end
  end

  dm_load_align u_load_align (
    .word    (mem[idx_c]),
    .addr_lo (addr_q[1:0]),
    .mode    (req_q.mode),
    .sext    (req_q.sext),
    .data_c  (load_c)
  );

  assign ready    = ready_q;
  assign done     = done_q;
  assign misalign = misalign_q;
  assign dout     = dout_q;

endmodule
